// File: rtl/md_unit_pkg.sv
// md_unit_pkg: op codes and FSM states shared by the multiply/divide unit
package md_unit_pkg;
  typedef enum logic {IDLE, RUN} md_state_e;
  localparam logic [3:0] MD_mult  = 4'd0;
  localparam logic [3:0] MD_multu = 4'd1;
  localparam logic [3:0] MD_div   = 4'd2;
  localparam logic [3:0] MD_divu  = 4'd3;
  localparam logic [3:0] MD_mthi  = 4'd4;
  localparam logic [3:0] MD_mtlo  = 4'd5;
  localparam logic [3:0] MD_madd  = 4'd6;
  localparam logic [3:0] MD_maddu = 4'd7;
  localparam logic [3:0] MD_msub  = 4'd8;
  localparam logic [3:0] MD_msubu = 4'd9;
  localparam logic [3:0] MD_none  = 4'd15;
  function automatic logic md_is_signed(input logic [3:0] op);
    return op == MD_mult || op == MD_div || op == MD_madd || op == MD_msub;
  endfunction
endpackage

// File: rtl/md_div_core.sv
// md_div_core: combinational signed/unsigned 32-bit divider (quotient, remainder)
module md_div_core (
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic [31:0] r
);
  logic [31:0] ua, ub, uq, ur;
  // Divide magnitudes, then restore signs: quotient toward zero, remainder follows dividend
  always_comb begin
    ua = (sgn && a[31]) ? -a : a;
    ub = (sgn && b[31]) ? -b : b;
    uq = (ub == 32'd0) ? 32'd0 : ua / ub;
    ur = (ub == 32'd0) ? 32'd0 : ua % ub;
    q  = (sgn && (a[31] ^ b[31])) ? -uq : uq;
    r  = (sgn && a[31]) ? -ur : ur;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/div unit with private HI/LO; MD_MADD_EN adds madd/maddu/msub/msubu
import md_unit_pkg::*;
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic        E_Start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  md_state_e state, state_n;
  logic [3:0] op;
  logic [31:0] a, b, q, r;
  logic [7:0] cnt, limit;
  logic [63:0] sa, sb, prod, res;
  logic start_ok, sg, is_div, acc_en, sub, done, commit;
`ifdef MD_MADD_EN
  assign start_ok = E_Start && !Busy && (E_MDOp inside {MD_mult, MD_multu, MD_div, MD_divu,
                                                        MD_madd, MD_maddu, MD_msub, MD_msubu});
`else
  assign start_ok = E_Start && !Busy && (E_MDOp inside {MD_mult, MD_multu, MD_div, MD_divu});
`endif
  assign Busy = state == RUN;
  md_div_core u_div (.sgn(sg), .a(a), .b(b), .q(q), .r(r));
  // Decode the latched op and form the result from latched operands and current HI/LO
  always_comb begin
    sg     = md_is_signed(op);
    is_div = op == MD_div || op == MD_divu;
    acc_en = op inside {MD_madd, MD_maddu, MD_msub, MD_msubu};
    sub    = op == MD_msub || op == MD_msubu;
    limit  = is_div ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
    done   = Busy && cnt == limit;
    commit = done && !(is_div && b == 32'd0);
    sa     = {{32{sg & a[31]}}, a};
    sb     = {{32{sg & b[31]}}, b};
    prod   = sa * sb;
    res    = is_div ? {r, q} : acc_en ? (sub ? {HI, LO} - prod : {HI, LO} + prod) : prod;
  end
  // Next-state: launch on an accepted start, return to IDLE on the final RUN cycle
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (start_ok ? RUN : IDLE) : (done ? IDLE : RUN);
  end
  // State register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Operand latch, run counter and HI/LO updates from results and moves
  always_ff @(posedge clk)
    if (reset) begin
      op  <= MD_none;
      a   <= '0;
      b   <= '0;
      cnt <= '0;
      HI  <= '0;
      LO  <= '0;
    end else begin
      if (start_ok) begin
        op  <= E_MDOp;
        a   <= E_A;
        b   <= E_B;
        cnt <= 8'd1;
      end else if (Busy) cnt <= cnt + 8'd1;
      if (commit) {HI, LO} <= res;
      else if (!Busy && !E_Start && E_MDOp == MD_mthi) HI <= E_A;
      else if (!Busy && !E_Start && E_MDOp == MD_mtlo) LO <= E_A;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core. It works alongside the branch comparator: operand comparison is single-cycle, while `mult/multu/div/divu` occupy this block for a fixed number of cycles and retire into its private HI/LO registers. It accepts an operation with a one-cycle start pulse and reports `Busy` so the hazard controller can stall later HI/LO consumers. It also implements `mthi/mtlo` and exposes HI/LO for `mfhi/mflo`.

## Interface
- `MULT_CYCLES`, 5, cycles `Busy` stays high after a multiply start.
- `DIV_CYCLES`, 10, cycles `Busy` stays high after a divide start.
- `clk  in  1`  system clock; all state changes on its rising edge.
- `reset  in  1`  synchronous, active-high reset.
- `E_MDOp  in  4`  operation code (constants `MD_*`); sampled only when `E_Start` or a move op is presented.
- `E_Start  in  1`  one-cycle pulse launching mult/multu/div/divu (and madd-family when enabled).
- `E_A  in  32`  rs operand.
- `E_B  in  32`  rt operand.
- `Busy  out  1`  operation in flight.
- `HI  out  32`  HI register.
- `LO  out  32`  LO register.

## Operation
- Reset: `Busy`=0, `HI`=0, `LO`=0, counter=0, FSM=IDLE.
- FSM states: IDLE, RUN. IDLE -> RUN on `E_Start` with a valid arithmetic op; RUN -> IDLE when the counter reaches the op's cycle count.
- On start, latch the op, `E_A`, and `E_B`. Compute the result from the latched operands. The result is committed to HI/LO only at the final RUN edge.
- mult: signed 32x32 -> 64, HI = [63:32], LO = [31:0]. multu: same, unsigned.
- div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. divu: unsigned.
- Divide by zero: the full `DIV_CYCLES` run still occurs; HI/LO are left unchanged.
- 0x80000000 / -1 (signed): LO = 0x80000000, HI = 0.
- mthi/mtlo (`E_MDOp` = `MD_mthi`/`MD_mtlo`, `E_Start`=0): write `E_A` into HI/LO at the next edge. `Busy` is unaffected. The move is ignored while `Busy`=1.
- `E_Start` while `Busy`=1 is ignored; the running op continues. The controller must never issue this case.
- `E_Start` with a non-arithmetic op code is ignored.
- `reset` mid-operation aborts the op: HI/LO=0 and `Busy`=0 at the next edge.

## Timing
- `E_Start` is high in cycle t. `Busy` is high for cycles t+1 … t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- The new HI/LO is visible from cycle t+N+1, the first cycle with `Busy`=0.
- The stall condition is `E_Start | Busy`. `Busy` does not cover the start cycle itself.
- Back-to-back ops: a new `E_Start` is accepted in cycle t+N+1.
- A move in cycle t updates HI/LO in cycle t+1.
- HI/LO are registered outputs with no combinational path from the inputs.

## Configuration
- `MD_MADD_EN` defined: `MD_madd`, `MD_maddu`, `MD_msub`, `MD_msubu` are accepted.
  - Run length is `MULT_CYCLES`.
  - Result is {HI,LO} ± product (64-bit wrap), using the HI/LO values present at the start edge.
- Not defined: these codes are treated as non-arithmetic, so `E_Start` is ignored.

## Structure
- `MD_*` op-code constants go in the shared `head.v`, next to the `CMP_*` constants.
- `MULT_CYCLES` and `DIV_CYCLES` defaults stay as module parameters.
- One sub-module is natural: `md_div_core`, a combinational signed/unsigned divider returning quotient and remainder. The multiply is inline.

## Test plan
- mult, A=0xFFFFFFFE (-2), B=3 -> `Busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at t+6.
- div, A=-7, B=2 -> `Busy` high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with B=0 -> HI/LO unchanged after 10 cycles.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated one cycle after each. An mtlo issued during a multiply is ignored.
- `reset` asserted in cycle t+3 of a div -> `Busy`=0, HI=LO=0 at t+4. A second `E_Start` at t+2 of a mult is ignored and the first result is still delivered at t+6.
- With `MD_MADD_EN`: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 -> HI=1, LO=0 after 5 cycles.
